// File: rtl/data_mem_pkg.sv
// Shared types and widths for the data-memory responder.
// Holds the responder FSM encoding and the address, data and burst-length widths.
// Imported by both the array and the responder top.
package data_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word memory: synchronous write, synchronous (registered) read.
// Read data appears the cycle after the address is presented; a write cycle leaves the read register unchanged.
// Contents are never reset.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // One access per cycle: either store the write word or register the addressed word
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: accepts LW/LM/SW/SM bursts of 1..8 words and plays them out one beat per cycle.
// First beat WAIT_CYCLES+1 cycles after acceptance; one idle cycle between bursts.
// Optional macro DATA_MEM_BUS_ERR_EN drives resp_err for out-of-range beats; otherwise resp_err is tied 0.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_last,
  output logic              resp_err,
  output logic              busy
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             r_state;
  logic [3:0]         r_wait_cnt;
  logic [LEN_W-1:0]   r_beat;
  logic [LEN_W-1:0]   r_len;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_beat_addr;   // address of the beat being presented this cycle
  logic               r_resp_valid;
  logic               r_resp_last;

  logic [ADDR_W-1:0]  w_next_addr;   // address of the beat that will be presented next cycle
  logic [IDX_W-1:0]   w_mem_idx;
  logic               w_mem_we;
  logic               w_oor;
  logic [DATA_W-1:0]  w_mem_rdata;

  assign req_ready = (r_state == IDLE) && !reset;

  // Next-beat address: the synchronous read must be issued one cycle ahead of the beat
  always_comb begin
    w_next_addr = r_addr;
    case (r_state)
      IDLE:    w_next_addr = req_addr;
      WAIT:    w_next_addr = r_addr;
      XFER:    w_next_addr = r_addr + ADDR_W'(r_beat) + 16'd1;
      default: w_next_addr = r_addr;
    endcase
  end

  assign w_oor    = {1'b0, r_beat_addr} >= DEPTH_L;
  // Writes land on the current beat's address; reads look one beat ahead
  assign w_mem_we  = (r_state == XFER) && r_we && !w_oor && !reset;
  assign w_mem_idx = ((r_state == XFER) && r_we) ? r_beat_addr[IDX_W-1:0]
                                                 : w_next_addr[IDX_W-1:0];

  data_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_idx),
    .i_wdata (req_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Burst FSM: accept in IDLE, count wait states, then emit len+1 beats with registered valid/last
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_beat       <= '0;
      r_len        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_beat_addr  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_last  <= 1'b0;
    end else begin
      r_beat_addr <= w_next_addr;
      case (r_state)
        IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_last  <= 1'b0;
          if (req_valid) begin
            r_addr     <= req_addr;
            r_we       <= req_we;
            r_len      <= req_len;
            r_beat     <= '0;
            r_wait_cnt <= '0;
            if (WAIT_CYCLES == 0) begin
              r_state      <= XFER;
              r_resp_valid <= 1'b1;
              r_resp_last  <= (req_len == '0);
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state      <= XFER;
            r_resp_valid <= 1'b1;
            r_resp_last  <= (r_len == '0);
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        XFER: begin
          if (r_beat == r_len) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_last  <= 1'b0;
          end else begin
            r_beat      <= r_beat + 1'b1;
            r_resp_last <= ((r_beat + 1'b1) == r_len);
          end
        end
        default: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_last  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_last  = r_resp_last;
  assign busy       = (r_state != IDLE);
  // Read data is forced to zero outside read beats and for out-of-range beats
  assign resp_rdata = (r_resp_valid && !r_we && !w_oor) ? w_mem_rdata : '0;

`ifdef DATA_MEM_BUS_ERR_EN
  assign resp_err = r_resp_valid && w_oor;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int W1    = 1;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        v0 = 1'b0;
  logic        v3 = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [2:0]  req_len = '0;
  logic [15:0] req_wdata = '0;

  logic        req_ready, resp_valid, resp_last, resp_err, busy;
  logic [15:0] resp_rdata;
  logic        rdy0, rv0, rl0, re0, bz0;
  logic [15:0] rd0;
  logic        rdy3, rv3, rl3, re3, bz3;
  logic [15:0] rd3;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_last(resp_last),
    .resp_err(resp_err), .busy(busy));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_last(rl0),
    .resp_err(re0), .busy(bz0));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_last(rl3),
    .resp_err(re3), .busy(bz3));

  int checks = 0;
  int errors = 0;
  logic [15:0] model [int];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [2:0]  len;
    logic [15:0] dat [8];
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 16'h0000);
    chk("rst_resp_last", resp_last, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
  endtask

  // Expected read data straight from the reference memory (unknown words are not checked)
  task automatic model_read(input logic [15:0] addr, input logic [2:0] len,
                            output logic [15:0] dat [8], output logic [7:0] known);
    logic [15:0] a;
    known = '0;
    for (int i = 0; i < 8; i++) begin
      dat[i] = 16'h0000;
      a = addr + 16'(i);
      if (i <= int'(len)) begin
        if (int'(a) >= DEPTH) begin
          known[i] = 1'b1;
        end else if (model.exists(int'(a))) begin
          dat[i] = model[int'(a)];
          known[i] = 1'b1;
        end
      end
    end
  endtask

  // One burst on the main instance: timing from acceptance is checked cycle by cycle
  task automatic run_burst(input logic we, input logic [15:0] addr, input logic [2:0] len,
                           input logic [15:0] dat [8], input logic [7:0] known, input logic hold);
    int n;
    int beat;
    int last_t;
    logic [15:0] a;
    logic exp_v;
    logic oor;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_wdata = dat[0];
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_when_idle", n, 0);
    if (n >= 20) return;
    beat   = 0;
    last_t = 1 + W1 + int'(len);
    for (int t = 1; t <= last_t; t++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      req_wdata = dat[beat];
      a     = addr + 16'(beat);
      exp_v = (t >= 1 + W1);
      oor   = (int'(a) >= DEPTH);
      chk("resp_valid", resp_valid, exp_v);
      chk("resp_last", resp_last, (t == last_t));
      chk("ready_low_in_burst", req_ready, 1'b0);
      chk("busy_in_burst", busy, 1'b1);
      if (!exp_v) begin
        chk("rdata_zero_when_idle", resp_rdata, 16'h0000);
        chk("err_zero_when_idle", resp_err, 1'b0);
      end else begin
        if (!we) begin
          if (oor) chk("rdata_out_of_range", resp_rdata, 16'h0000);
          else if (known[beat]) chk("rdata", resp_rdata, dat[beat]);
        end
`ifdef DATA_MEM_BUS_ERR_EN
        chk("resp_err", resp_err, oor);
`else
        chk("resp_err", resp_err, 1'b0);
`endif
        beat++;
      end
    end
    if (we) begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + 16'(i);
        if (int'(a) < DEPTH) model[int'(a)] = dat[i];
      end
    end
  endtask

  // Single-word read on a fixed-latency instance; report the cycle of the first beat
  task automatic lat_check(input int w);
    int first;
    logic rv;
    logic rdy;
    first = -1;
    @(negedge clk);
    req_we   = 1'b0;
    req_addr = 16'h0010;
    req_len  = 3'd0;
    if (w == 0) v0 = 1'b1; else v3 = 1'b1;
    rdy = (w == 0) ? rdy0 : rdy3;
    chk("lat_ready", rdy, 1'b1);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      v0 = 1'b0;
      v3 = 1'b0;
      rv = (w == 0) ? rv0 : rv3;
      if (first < 0 && rv === 1'b1) first = t;
    end
    chk("first_beat_latency", first, w + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [15:0] d [8];
    logic [7:0]  k;
    logic        we;
    logic [15:0] addr;
    logic [2:0]  len;
    int          sel;
    int          beat;
    int          n;

    // Directed vectors: write data, or expected read data for read entries
    for (int i = 0; i < 6; i++) begin
      tbl[i].we = 1'b0; tbl[i].addr = '0; tbl[i].len = '0;
      for (int j = 0; j < 8; j++) tbl[i].dat[j] = 16'h0000;
    end
    tbl[0].we = 1'b1; tbl[0].addr = 16'h0010; tbl[0].len = 3'd0; tbl[0].dat[0] = 16'hBEEF;
    tbl[1].we = 1'b0; tbl[1].addr = 16'h0010; tbl[1].len = 3'd0; tbl[1].dat[0] = 16'hBEEF;
    tbl[2].we = 1'b1; tbl[2].addr = 16'h0020; tbl[2].len = 3'd7;
    tbl[3].we = 1'b0; tbl[3].addr = 16'h0020; tbl[3].len = 3'd7;
    for (int j = 0; j < 8; j++) begin
      tbl[2].dat[j] = 16'h1000 + 16'(j);
      tbl[3].dat[j] = 16'h1000 + 16'(j);
    end
    tbl[4].we = 1'b1; tbl[4].addr = 16'h0000; tbl[4].len = 3'd1;
    tbl[4].dat[0] = 16'h5A00; tbl[4].dat[1] = 16'h5A01;
    tbl[5].we = 1'b0; tbl[5].addr = 16'hFFFE; tbl[5].len = 3'd3;
    tbl[5].dat[2] = 16'h5A00; tbl[5].dat[3] = 16'h5A01;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_burst(tbl[i].we, tbl[i].addr, tbl[i].len, tbl[i].dat, 8'hFF, 1'b0);
    end

    lat_check(0);
    lat_check(3);

    // Back-to-back with req_valid held: second request must be taken right after the idle cycle
    model_read(16'h0020, 3'd1, d, k);
    run_burst(1'b0, 16'h0020, 3'd1, d, k, 1'b1);
    model_read(16'h0010, 3'd0, d, k);
    run_burst(1'b0, 16'h0010, 3'd0, d, k, 1'b0);

    // Reset during beat 3 of an 8-beat write
    for (int j = 0; j < 8; j++) d[j] = 16'h7700 + 16'(j);
    run_burst(1'b1, 16'h0080, 3'd7, d, 8'hFF, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0080; req_len = 3'd7; req_wdata = 16'h2000;
    chk("ready_before_abort", req_ready, 1'b1);
    beat = 0;
    n = 0;
    while (beat < 3 && n < 10) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = 16'h2000 + 16'(beat);
      if (resp_valid === 1'b1) beat++;
      n++;
    end
    chk("abort_reached_beat3", beat, 3);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    model[16'h0080] = 16'h2000;
    model[16'h0081] = 16'h2001;
    model.delete(16'h0082);
    model_read(16'h0080, 3'd7, d, k);
    run_burst(1'b0, 16'h0080, 3'd7, d, k, 1'b0);

    // Randomised bursts against the reference memory
    for (int it = 0; it < 40; it++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 7)      addr = 16'h0040 + 16'($urandom_range(0, 31));
      else if (sel < 9) addr = 16'h00FA + 16'($urandom_range(0, 4));
      else              addr = 16'hFFFA + 16'($urandom_range(0, 3));
      len = 3'($urandom_range(0, 7));
      if (we) begin
        for (int j = 0; j < 8; j++) d[j] = 16'($urandom());
        k = 8'hFF;
      end else begin
        model_read(addr, len, d, k);
      end
      run_burst(we, addr, len, d, k, 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;

    // Memory survives reset: re-read the directed areas
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_read(16'h0020, 3'd7, d, k);
    run_burst(1'b0, 16'h0020, 3'd7, d, k, 1'b0);
    model_read(16'h0010, 3'd0, d, k);
    run_burst(1'b0, 16'h0010, 3'd0, d, k, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 16-bit words in the memory array.
REQ-002 Parameter WAIT_CYCLES, default 1: wait states between request acceptance and the first beat; legal range 0..15.
REQ-003 Port clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req_valid, input, 1 bit: memory-stage request present.
REQ-006 Port req_ready, output, 1 bit: responder can accept a request.
REQ-007 Port req_we, input, 1 bit: 1 selects write (SW/SM), 0 selects read (LW/LM).
REQ-008 Port req_addr, input, 16 bits: word address of the first beat.
REQ-009 Port req_len, input, 3 bits: beat count minus one (0..7 gives 1..8 beats, the LM/SM register span).
REQ-010 Port req_wdata, input, 16 bits: write data for the current write beat.
REQ-011 Port resp_valid, output, 1 bit: beat completes this cycle (read data valid, or write performed).
REQ-012 Port resp_rdata, output, 16 bits: read data for the current beat.
REQ-013 Port resp_last, output, 1 bit: final beat of the burst.
REQ-014 Port resp_err, output, 1 bit: current beat's address is out of range (BUS_ERR_EN only; otherwise tied 0).
REQ-015 Port busy, output, 1 bit: state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and XFER.
REQ-017 req_ready SHALL be 1 only in IDLE and not during reset.
REQ-018 Acceptance SHALL occur when req_valid && req_ready: addr, we and len are latched, and the beat counter is cleared.
REQ-019 After acceptance, the FSM SHALL go to WAIT if WAIT_CYCLES>0, otherwise directly to XFER.
REQ-020 WAIT SHALL last exactly WAIT_CYCLES cycles, then move to XFER.
REQ-021 For reads, with acceptance at edge N, the first resp_valid SHALL appear in cycle N+1+WAIT_CYCLES.
REQ-022 XFER SHALL produce one beat per cycle with resp_valid=1, for len+1 consecutive cycles, with no stalls.
REQ-023 There is no response backpressure.
REQ-024 The beat i address SHALL be latched_addr+i, computed modulo 2^16 (wrap-around).
REQ-025 On a write beat, the responder SHALL store the req_wdata present in that cycle.
REQ-026 The requester SHALL present the next word after each resp_valid.
REQ-027 resp_rdata SHALL be registered and valid only while resp_valid=1; it SHALL hold 0 otherwise.
REQ-028 resp_last SHALL be 1 only with the final beat.
REQ-029 The FSM SHALL return to IDLE on the edge after the last beat, giving one idle cycle between back-to-back requests.
REQ-030 For an out-of-range beat (address >= DEPTH), a write SHALL be discarded and a read SHALL return 0x0000.
REQ-031 A read of an address written earlier in the same or a previous burst SHALL return the new value.
REQ-032 req_* inputs SHALL be ignored outside IDLE, except req_wdata during write beats.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE and the counters SHALL clear.
REQ-034 Reset values SHALL be: resp_valid=0, resp_rdata=0, resp_last=0, resp_err=0, busy=0; req_ready becomes 1 on the first cycle after reset deasserts.
REQ-035 Reset mid-burst SHALL abort the burst; no further writes occur, and already-written words keep their values.
REQ-036 Memory contents SHALL be unaffected by reset.

Configuration
REQ-037 With macro DATA_MEM_BUS_ERR_EN defined, resp_err SHALL equal (beat address >= DEPTH) and be qualified by resp_valid.
REQ-038 Without DATA_MEM_BUS_ERR_EN, resp_err SHALL be constant 0 and no range-error logic is built; out-of-range behaviour is still per REQ-030.

Structure
REQ-039 Package data_mem_pkg SHALL hold the state enum (IDLE/WAIT/XFER), ADDR_W=16, DATA_W=16 and LEN_W=3.
REQ-040 A single sub-module, data_mem_array, SHALL implement a single-port synchronous-read, synchronous-write array of DEPTH words.

Verification
REQ-041 Write 0xBEEF to address 0x0010 with len=0 and WAIT_CYCLES=1 -> a single resp_valid with resp_last=1 two cycles after acceptance; a later read of 0x0010 returns 0xBEEF.
REQ-042 Write burst at 0x0020 with len=7 and data 0x1000..0x1007, then read burst with len=7 -> 8 consecutive beats returning 0x1000..0x1007, resp_last on beat 8, and req_ready=0 throughout.
REQ-043 WAIT_CYCLES=0: read accepted at edge N -> resp_valid in cycle N+1; WAIT_CYCLES=3 -> resp_valid in cycle N+4.
REQ-044 Read burst at 0xFFFE with len=3 and DEPTH=256, BUS_ERR_EN defined -> addresses FFFE, FFFF, 0000, 0001; the first two beats return 0x0000 with resp_err=1, the last two return memory data with resp_err=0.
REQ-045 Reset asserted on beat 3 of an 8-beat write -> outputs go to reset values, beats 4..8 are not written, and the next request is accepted normally.
REQ-046 req_valid held high across back-to-back requests -> the second request is accepted exactly one cycle after the first burst's last beat.
